// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared types and constants for the frame accumulator.
//   acc_state_t  accumulator FSM state (idle / frame in progress)
//   IN_W_DEF     default product width (8x8 multiplier output)
//   ACC_W_DEF    default accumulator / output width
//   cnt_w()      frame counter width for a given frame length
package mul_acc_pkg;

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } acc_state_t;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF = 24;

    function automatic int unsigned cnt_w(int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

// File: rtl/mul_acc_out_reg.sv
// mul_acc_out_reg: one-entry valid/ready holding register for completed frame sums.
// A load offered while the register is full and not being drained is dropped and
// recorded in a sticky overrun flag.
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   clr_i        clears the overrun flag only
//   load_i       a completed frame sum is offered this cycle
//   load_data_i  sum to load
//   load_sat_i   sum was clamped
//   ready_i      downstream accepts data_o
//   valid_o      register holds a sum
//   data_o       held sum
//   sat_o        held sum was clamped
//   overrun_o    sticky: a load was dropped
module mul_acc_out_reg #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_data_i,
    input  logic             load_sat_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [ACC_W-1:0] data_o,
    output logic             sat_o,
    output logic             overrun_o
);

    logic             valid_q, valid_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;
        // Transfer completes this cycle; a load below may refill the slot.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = load_data_i;
                sat_d   = load_sat_i;
            end else begin
                // Full and stalled: keep the held sum, drop the new one.
                ovr_d = 1'b1;
            end
        end
        if (clr_i) begin
            ovr_d = 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign sat_o     = sat_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/mul_acc_frame.sv
// mul_acc_frame: accumulates FRAME_LEN consecutive valid multiplier products into one
// frame sum and presents it on a one-entry valid/ready output register. The upstream
// multiplier cannot be stalled, so a sum that finds the output full is dropped and
// flagged via the sticky overrun output.
// Build option: define MUL_ACC_FRAME_SAT_EN to clamp each addition at 2^ACC_W-1 and
// report clamping on out_sat; otherwise sums wrap and out_sat is constant 0.
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   product valid (multiplier mul_en_out)
//   in_data    unsigned product (multiplier mul_out)
//   clr        abort the partial frame and clear overrun
//   out_ready  downstream accepts out_data
//   out_valid  frame sum held in the output register
//   out_data   frame sum
//   out_sat    frame sum was clamped
//   overrun    sticky: a completed frame was dropped
module mul_acc_frame
    import mul_acc_pkg::*;
#(
    parameter int unsigned IN_W      = IN_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             overrun
);

    localparam int unsigned    CntW    = cnt_w(FRAME_LEN);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);

    acc_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum_next;
    logic             clamp;
    logic             frame_done;
    logic             frame_sat;

    assign in_ext = ACC_W'(in_data);

`ifdef MUL_ACC_FRAME_SAT_EN
    logic [ACC_W:0] add_wide;
    assign add_wide = {1'b0, acc_q} + {1'b0, in_ext};
    // Carry out means the true sum exceeds the register range.
    assign clamp    = add_wide[ACC_W];
    assign sum_next = clamp ? {ACC_W{1'b1}} : add_wide[ACC_W-1:0];
`else
    assign clamp    = 1'b0;
    assign sum_next = acc_q + in_ext;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACC_IDLE;
        end else if (in_valid) begin
            unique case (state_q)
                ACC_IDLE: state_d = ACC_RUN;
                ACC_RUN:  if (cnt_q == CntLast) state_d = ACC_IDLE;
                default:  state_d = ACC_IDLE;
            endcase
        end
    end

    // Datapath / output decode
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        frame_done = 1'b0;
        frame_sat  = sat_q | clamp;
        // clr has priority; a same-cycle product is discarded.
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
            sat_d = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                ACC_IDLE: begin
                    acc_d = in_ext;
                    cnt_d = CntOne;
                    sat_d = 1'b0;
                end
                ACC_RUN: begin
                    if (cnt_q == CntLast) begin
                        frame_done = 1'b1;
                        cnt_d      = '0;
                        acc_d      = '0;
                        sat_d      = 1'b0;
                    end else begin
                        acc_d = sum_next;
                        cnt_d = cnt_q + CntOne;
                        sat_d = sat_q | clamp;
                    end
                end
                default: begin
                    cnt_d = '0;
                    acc_d = '0;
                    sat_d = 1'b0;
                end
            endcase
        end
    end

    // frame_sat is always 0 in the wrap-around build, so out_sat stays 0.
    mul_acc_out_reg #(
        .ACC_W(ACC_W)
    ) u_out_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .load_i      (frame_done),
        .load_data_i (sum_next),
        .load_sat_i  (frame_sat),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .sat_o       (out_sat),
        .overrun_o   (overrun)
    );

endmodule
